// File: rtl/maze_game_engine.sv
// Maze game engine: tracks the player on a MAP_W x MAP_H tile maze, checks each
// move against a wall map in an external synchronous ROM, and keeps lives, move count and win/loss.
module maze_game_engine #(
  parameter int MAP_W   = 30,
  parameter int MAP_H   = 21,
  parameter int POS_W   = 8,
  parameter int ADDR_W  = 5,
  parameter int START_X = 0,
  parameter int START_Y = 20,
  parameter int GOAL_X  = 29,
  parameter int GOAL_Y  = 0,
  parameter int LIVES   = 3,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [3:0]        i_move_en,
  output logic [ADDR_W-1:0] o_map_addr,
  input  logic [MAP_W-1:0]  i_map_data,
  output logic [POS_W-1:0]  o_player_x_pos,
  output logic [POS_W-1:0]  o_player_y_pos,
  output logic [3:0]        o_lives,
  output logic [CNT_W-1:0]  o_move_count,
  output logic              o_busy,
  output logic              o_hit,
  output logic              o_reject,
  output logic              o_lost,
  output logic              o_won
);

  localparam logic [POS_W-1:0]  MAX_X    = POS_W'(MAP_W - 1);
  localparam logic [POS_W-1:0]  MAX_Y    = POS_W'(MAP_H - 1);
  localparam logic [POS_W-1:0]  INIT_X   = POS_W'(START_X);
  localparam logic [POS_W-1:0]  INIT_Y   = POS_W'(START_Y);
  localparam logic [POS_W-1:0]  GOAL_XP  = POS_W'(GOAL_X);
  localparam logic [POS_W-1:0]  GOAL_YP  = POS_W'(GOAL_Y);
  localparam logic [ADDR_W-1:0] INIT_A   = ADDR_W'(START_Y);
  localparam logic [3:0]        INIT_LIV = 4'(LIVES);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EVAL,
    LOST,
    WON
  } state_t;

  state_t              r_state, w_stateNxt;
  logic [POS_W-1:0]    r_x, r_y, r_tgtX, r_tgtY;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_lives;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy, r_hit, r_reject, r_lost, r_won;

  logic [POS_W-1:0]    w_xNxt, w_yNxt, w_tgtXNxt, w_tgtYNxt;
  logic [ADDR_W-1:0]   w_addrNxt;
  logic [3:0]          w_livesNxt;
  logic [CNT_W-1:0]    w_cntNxt;
  logic                w_busyNxt, w_hitNxt, w_rejectNxt, w_lostNxt, w_wonNxt;

  logic                w_req, w_oob, w_wall;
  logic [POS_W-1:0]    w_tx, w_ty;

  assign w_req  = |i_move_en;
  assign w_wall = |(i_map_data & (MAP_W'(1) << r_tgtX));

  // Target tile for the highest-priority requested direction (up > down > left > right).
  always_comb begin
    w_tx  = r_x;
    w_ty  = r_y;
    w_oob = 1'b0;
    if (i_move_en[0]) begin
      if (r_y == '0) w_oob = 1'b1;
      else           w_ty  = r_y - POS_W'(1);
    end else if (i_move_en[1]) begin
      if (r_y >= MAX_Y) w_oob = 1'b1;
      else              w_ty  = r_y + POS_W'(1);
    end else if (i_move_en[2]) begin
      if (r_x == '0) w_oob = 1'b1;
      else           w_tx  = r_x - POS_W'(1);
    end else if (i_move_en[3]) begin
      if (r_x >= MAX_X) w_oob = 1'b1;
      else              w_tx  = r_x + POS_W'(1);
    end
  end

  always_comb begin
    w_stateNxt  = r_state;
    w_xNxt      = r_x;
    w_yNxt      = r_y;
    w_tgtXNxt   = r_tgtX;
    w_tgtYNxt   = r_tgtY;
    w_addrNxt   = r_addr;
    w_livesNxt  = r_lives;
    w_cntNxt    = r_cnt;
    w_busyNxt   = r_busy;
    w_hitNxt    = 1'b0;
    w_rejectNxt = 1'b0;
    w_lostNxt   = r_lost;
    w_wonNxt    = r_won;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_oob) begin
            w_rejectNxt = 1'b1;
          end else begin
            w_tgtXNxt  = w_tx;
            w_tgtYNxt  = w_ty;
            w_addrNxt  = ADDR_W'(w_ty);
            w_busyNxt  = 1'b1;
            w_stateNxt = FETCH;
          end
        end
      end

      // ROM row for the target is being read this cycle.
      FETCH: w_stateNxt = EVAL;

      EVAL: begin
        w_busyNxt = 1'b0;
        if (w_wall) begin
          w_hitNxt   = 1'b1;
          w_livesNxt = r_lives - 4'd1;
          if (r_lives == 4'd1) begin
            w_lostNxt  = 1'b1;
            w_stateNxt = LOST;
          end else begin
            w_stateNxt = IDLE;
          end
        end else begin
          w_xNxt   = r_tgtX;
          w_yNxt   = r_tgtY;
          w_cntNxt = r_cnt + CNT_W'(1);
          if (r_tgtX == GOAL_XP && r_tgtY == GOAL_YP) begin
            w_wonNxt   = 1'b1;
            w_stateNxt = WON;
          end else begin
            w_stateNxt = IDLE;
          end
        end
      end

      LOST, WON: w_stateNxt = r_state;

      default: w_stateNxt = IDLE;
    endcase
  end

  // Reset wins over any in-flight move so no partial update can land.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_x      <= INIT_X;
      r_y      <= INIT_Y;
      r_tgtX   <= INIT_X;
      r_tgtY   <= INIT_Y;
      r_addr   <= INIT_A;
      r_lives  <= INIT_LIV;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_hit    <= 1'b0;
      r_reject <= 1'b0;
      r_lost   <= 1'b0;
      r_won    <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_x      <= w_xNxt;
      r_y      <= w_yNxt;
      r_tgtX   <= w_tgtXNxt;
      r_tgtY   <= w_tgtYNxt;
      r_addr   <= w_addrNxt;
      r_lives  <= w_livesNxt;
      r_cnt    <= w_cntNxt;
      r_busy   <= w_busyNxt;
      r_hit    <= w_hitNxt;
      r_reject <= w_rejectNxt;
      r_lost   <= w_lostNxt;
      r_won    <= w_wonNxt;
    end
  end

  assign o_map_addr     = r_addr;
  assign o_player_x_pos = r_x;
  assign o_player_y_pos = r_y;
  assign o_lives        = r_lives;
  assign o_move_count   = r_cnt;
  assign o_busy         = r_busy;
  assign o_hit          = r_hit;
  assign o_reject       = r_reject;
  assign o_lost         = r_lost;
  assign o_won          = r_won;

endmodule

// File: tb/tb_maze_game_engine.sv
// Directed bench for maze_game_engine: a behavioural ROM plus a move model whose
// expected results go through a scoreboard queue and are checked when the DUT settles.
module tb_maze_game_engine;

  logic        clk;
  logic        reset;
  logic [3:0]  moveEn;
  logic [4:0]  mapAddr;
  logic [29:0] mapData;
  logic [7:0]  playerX, playerY;
  logic [3:0]  lives;
  logic [15:0] moveCount;
  logic        busy, hit, reject, lost, won;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int kind;
    int x, y, lives, cnt, addr;
    bit hit, lost, won;
  } exp_t;
  exp_t sbq[$];

  logic [29:0] tbMap [0:31];
  int mX, mY, mLives, mCnt, mAddr;
  bit mLost, mWon;

  maze_game_engine dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_move_en      (moveEn),
    .o_map_addr     (mapAddr),
    .i_map_data     (mapData),
    .o_player_x_pos (playerX),
    .o_player_y_pos (playerY),
    .o_lives        (lives),
    .o_move_count   (moveCount),
    .o_busy         (busy),
    .o_hit          (hit),
    .o_reject       (reject),
    .o_lost         (lost),
    .o_won          (won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mapData <= tbMap[mapAddr];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clearMap();
    for (int r = 0; r < 32; r++) tbMap[r] = '0;
  endtask

  task automatic checkFull(input string tag);
    cmp({tag, " x"}, 32'(playerX), mX);
    cmp({tag, " y"}, 32'(playerY), mY);
    cmp({tag, " lives"}, 32'(lives), mLives);
    cmp({tag, " cnt"}, 32'(moveCount), mCnt);
    cmp({tag, " lost"}, 32'(lost), 32'(mLost));
    cmp({tag, " won"}, 32'(won), 32'(mWon));
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    moveEn = 4'b0;
    @(negedge clk);
    reset = 1'b0;
    mX = 0; mY = 20; mLives = 3; mCnt = 0; mAddr = 20; mLost = 0; mWon = 0;
    checkFull(tag);
    cmp({tag, " busy"}, 32'(busy), 0);
    cmp({tag, " hit"}, 32'(hit), 0);
    cmp({tag, " reject"}, 32'(reject), 0);
    cmp({tag, " addr"}, 32'(mapAddr), 20);
  endtask

  // Model of one move request, evaluated from the spec rules against tbMap.
  task automatic modelMove(input logic [3:0] mv);
    exp_t e;
    int nx, ny;
    bit oob;
    nx = mX; ny = mY; oob = 0;
    if (mv[0])      begin ny = mY - 1; oob = (ny < 0); end
    else if (mv[1]) begin ny = mY + 1; oob = (ny > 20); end
    else if (mv[2]) begin nx = mX - 1; oob = (nx < 0); end
    else if (mv[3]) begin nx = mX + 1; oob = (nx > 29); end
    e.hit = 0;
    if (mLost || mWon || mv == 4'b0) e.kind = 0;
    else if (oob) e.kind = 1;
    else begin
      e.kind = 2;
      mAddr = ny;
      if (tbMap[ny][nx]) begin
        e.hit = 1;
        mLives = mLives - 1;
        if (mLives == 0) mLost = 1;
      end else begin
        mX = nx; mY = ny;
        mCnt = (mCnt + 1) % 65536;
        if (mX == 29 && mY == 0) mWon = 1;
      end
    end
    e.x = mX; e.y = mY; e.lives = mLives; e.cnt = mCnt; e.addr = mAddr;
    e.lost = mLost; e.won = mWon;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      cmp({tag, " sbq empty"}, 32'(sbq.size()), 1);
      return;
    end
    e = sbq.pop_front();
    cmp({tag, " x"}, 32'(playerX), e.x);
    cmp({tag, " y"}, 32'(playerY), e.y);
    cmp({tag, " lives"}, 32'(lives), e.lives);
    cmp({tag, " cnt"}, 32'(moveCount), e.cnt);
    cmp({tag, " hit"}, 32'(hit), 32'(e.hit));
    cmp({tag, " lost"}, 32'(lost), 32'(e.lost));
    cmp({tag, " won"}, 32'(won), 32'(e.won));
    cmp({tag, " busy3"}, 32'(busy), 0);
    cmp({tag, " addr"}, 32'(mapAddr), e.addr);
  endtask

  // Drive mv for one cycle, optionally keep poking busyMv while the DUT is busy.
  task automatic applyStimulus(input string tag, input logic [3:0] mv, input logic [3:0] busyMv);
    int kind;
    @(negedge clk);
    moveEn = mv;
    modelMove(mv);
    kind = sbq[sbq.size() - 1].kind;
    @(negedge clk);
    moveEn = busyMv;
    cmp({tag, " busy1"}, 32'(busy), 32'(kind == 2));
    cmp({tag, " reject1"}, 32'(reject), 32'(kind == 1));
    cmp({tag, " hit1"}, 32'(hit), 0);
    @(negedge clk);
    cmp({tag, " busy2"}, 32'(busy), 32'(kind == 2));
    cmp({tag, " reject2"}, 32'(reject), 0);
    @(negedge clk);
    moveEn = 4'b0;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1;
    moveEn = 4'b0;
    clearMap();
    repeat (2) @(negedge clk);

    doReset("rst0");
    applyStimulus("right1", 4'b1000, 4'b0000);

    // Wall above start: three hits drain the lives.
    doReset("rst1");
    tbMap[19] = 30'h1;
    applyStimulus("wall1", 4'b0001, 4'b0000);
    applyStimulus("wall2", 4'b0001, 4'b0000);
    applyStimulus("wall3", 4'b0001, 4'b0000);
    applyStimulus("lostHold", 4'b1000, 4'b0000);
    clearMap();

    doReset("rst2");
    applyStimulus("rejLeft", 4'b0100, 4'b0000);
    applyStimulus("rejDown", 4'b0010, 4'b0000);

    // All bits at once take up only; pokes during busy are dropped.
    doReset("rst3");
    applyStimulus("prio", 4'b1111, 4'b1000);
    applyStimulus("idleGap", 4'b0000, 4'b0000);

    doReset("rst4");
    for (int i = 0; i < 20; i++) applyStimulus("pathUp", 4'b0001, 4'b0000);
    for (int i = 0; i < 29; i++) applyStimulus("pathRight", 4'b1000, 4'b0000);
    cmp("goal won", 32'(won), 1);
    applyStimulus("wonHold", 4'b0010, 4'b0000);
    doReset("rstAfterWin");

    // Reset landing in the FETCH cycle aborts the move completely.
    @(negedge clk);
    moveEn = 4'b1000;
    @(negedge clk);
    moveEn = 4'b0;
    cmp("abort busy1", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp("abort x", 32'(playerX), 0);
    cmp("abort y", 32'(playerY), 20);
    cmp("abort busy", 32'(busy), 0);
    cmp("abort cnt", 32'(moveCount), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("abort hit", 32'(hit), 0);
      cmp("abort xHold", 32'(playerX), 0);
      cmp("abort cntHold", 32'(moveCount), 0);
    end

    cmp("sbq drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
